// File: rtl/iommu_pkg.sv
// Shared types and constants for the IOMMU translation stage.
package iommu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WALK,
    CHECK,
    ACCESS,
    RESP
  } state_t;

  localparam int PTE_V = 0;
  localparam int PTE_W = 1;
  localparam int PTE_BYTES = 4;
  localparam int PTE_SHIFT = $clog2(PTE_BYTES);

endpackage

// File: rtl/iommu_if.sv
// Device-side request/response bundle plus the physical memory port.
interface iommu_if;

  logic [31:0] iommu_daddr;
  logic        iommu_translate_request;
  logic        iommu_write_en;
  logic [31:0] iommu_write_data;
  logic [31:0] iommu_paddr;
  logic [31:0] iommu_data_out;
  logic        iommu_translation_done;
  logic        iommu_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output iommu_daddr,
    output iommu_translate_request,
    output iommu_write_en,
    output iommu_write_data,
    input  iommu_paddr,
    input  iommu_data_out,
    input  iommu_translation_done,
    input  iommu_fault,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

  modport slave (
    input  iommu_daddr,
    input  iommu_translate_request,
    input  iommu_write_en,
    input  iommu_write_data,
    output iommu_paddr,
    output iommu_data_out,
    output iommu_translation_done,
    output iommu_fault,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

endinterface

// File: rtl/iommu_tlb.sv
// Direct-mapped TLB: combinational lookup, synchronous fill and flush.
module iommu_tlb #(
  parameter int ENTRIES   = 8,
  parameter int PAGE_BITS = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [31-PAGE_BITS:0] vpn,
  output logic                 hit,
  output logic [31-PAGE_BITS:0] ppn,
  output logic                 w,
  input  logic                 fill,
  input  logic [31-PAGE_BITS:0] fill_ppn,
  input  logic                 fill_w
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int VPN_W = 32 - PAGE_BITS;
  localparam int TAG_W = VPN_W - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] ws;
  logic [TAG_W-1:0]   tags [ENTRIES];
  logic [VPN_W-1:0]   ppns [ENTRIES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign idx = vpn[IDX_W-1:0];
  assign tag = vpn[VPN_W-1:IDX_W];
  assign hit = valid[idx] && (tags[idx] == tag);
  assign ppn = ppns[idx];
  assign w   = ws[idx];

  // Flush takes priority over a fill landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= '0;
    end else if (fill) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tags[idx] <= tag;
      ppns[idx] <= fill_ppn;
      ws[idx]   <= fill_w;
    end
  end

endmodule

// File: rtl/iommu_unit.sv
// IOMMU stage: TLB lookup, one-level page walk, then one data access.
module iommu_unit
  import iommu_pkg::*;
#(
  parameter int TLB_ENTRIES = 8,
  parameter int PAGE_BITS   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pt_base,
  input  logic        tlb_flush,
  iommu_if.slave      bus
);

  localparam int VPN_W = 32 - PAGE_BITS;

  state_t state, nxt;

  logic             armed;
  logic             start;
  logic [31:0]      daddr_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic [31:0]      pte_addr;
  logic [VPN_W-1:0] pte_ppn;
  logic             pte_v;
  logic             pte_w;
  logic             pte_ok;
  logic [VPN_W-1:0] ppn_q;
  logic [31:0]      paddr_q;
  logic [31:0]      data_q;
  logic             fault_q;
  logic             flush_seen;
  logic             fill;
  logic [VPN_W-1:0] vpn;
  logic [31:0]      phys;
  logic             hit;
  logic             hit_w;
  logic [VPN_W-1:0] hit_ppn;

  assign vpn    = daddr_q[31:PAGE_BITS];
  assign phys   = {ppn_q, daddr_q[PAGE_BITS-1:0]};
  assign start  = (state == IDLE) && bus.iommu_translate_request && armed;
  assign pte_ok = pte_v && (!we_q || pte_w);
  assign fill   = (state == CHECK) && pte_ok && !flush_seen;

  iommu_tlb #(
    .ENTRIES  (TLB_ENTRIES),
    .PAGE_BITS(PAGE_BITS)
  ) u_tlb (
    .clk     (clk),
    .reset   (reset),
    .flush   (tlb_flush),
    .vpn     (vpn),
    .hit     (hit),
    .ppn     (hit_ppn),
    .w       (hit_w),
    .fill    (fill),
    .fill_ppn(pte_ppn),
    .fill_w  (pte_w)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (start) nxt = LOOKUP;
      LOOKUP: begin
        if (!hit)              nxt = WALK;
        else if (we_q && !hit_w) nxt = RESP;
        else                   nxt = ACCESS;
      end
      WALK:   if (bus.mem_ack) nxt = CHECK;
      CHECK:  nxt = pte_ok ? ACCESS : RESP;
      ACCESS: if (bus.mem_ack) nxt = RESP;
      RESP:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      state == WALK: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = pte_addr;
      end
      state == ACCESS: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = phys;
        bus.mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed      <= 1'b1;
      daddr_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      pte_addr   <= '0;
      pte_ppn    <= '0;
      pte_v      <= 1'b0;
      pte_w      <= 1'b0;
      ppn_q      <= '0;
      paddr_q    <= '0;
      data_q     <= '0;
      fault_q    <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      // A held request must drop once before it can start again.
      if (start) begin
        armed      <= 1'b0;
        daddr_q    <= bus.iommu_daddr;
        we_q       <= bus.iommu_write_en;
        wdata_q    <= bus.iommu_write_data;
        fault_q    <= 1'b0;
        flush_seen <= 1'b0;
      end else if (!bus.iommu_translate_request) begin
        armed <= 1'b1;
      end
      if ((state == WALK || state == CHECK) && tlb_flush)
        flush_seen <= 1'b1;
      unique case (state)
        LOOKUP: begin
          if (!hit) begin
            pte_addr <= pt_base + (32'(vpn) << PTE_SHIFT);
          end else if (we_q && !hit_w) begin
            fault_q <= 1'b1;
            paddr_q <= '0;
            data_q  <= '0;
          end else begin
            ppn_q <= hit_ppn;
          end
        end
        WALK: if (bus.mem_ack) begin
          pte_ppn <= bus.mem_rdata[31:PAGE_BITS];
          pte_v   <= bus.mem_rdata[PTE_V];
          pte_w   <= bus.mem_rdata[PTE_W];
        end
        CHECK: begin
          if (pte_ok) begin
            ppn_q <= pte_ppn;
          end else begin
            fault_q <= 1'b1;
            paddr_q <= '0;
            data_q  <= '0;
          end
        end
        ACCESS: if (bus.mem_ack) begin
          paddr_q <= phys;
          if (!we_q) data_q <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.iommu_translation_done = (state == RESP);
  assign bus.iommu_fault            = (state == RESP) && fault_q;
  assign bus.iommu_paddr            = paddr_q;
  assign bus.iommu_data_out         = data_q;

endmodule

// File: tb/tb_iommu_unit.sv
// Scoreboard bench for iommu_unit with a small zero/stall-wait memory model.
module tb_iommu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pt_base = 32'h0001_0000;
  logic        tlb_flush = 1'b0;
  logic        stall = 1'b0;

  iommu_if bus ();

  iommu_unit #(.TLB_ENTRIES(8), .PAGE_BITS(12)) dut (
    .clk      (clk),
    .reset    (reset),
    .pt_base  (pt_base),
    .tlb_flush(tlb_flush),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] paddr;
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          acc;
    int          cyc0;
    int          acc0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  logic [31:0] wr_mem [logic [31:0]];

  function automatic logic [31:0] init_mem(input logic [31:0] a);
    case (a)
      32'h0001_000C: return 32'h0008_7003;
      32'h0008_7ABC: return 32'hDEAD_BEEF;
      32'h0001_0014: return 32'h0000_0000;
      32'h0001_0018: return 32'h0009_0001;
      32'h0009_0010: return 32'hCAFE_0001;
      32'h0001_001C: return 32'h000A_0001;
      32'h0001_0020: return 32'h000B_0003;
      32'h000B_0040: return 32'h0BAD_F00D;
      default:       return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (wr_mem.exists(a)) return wr_mem[a];
    return init_mem(a);
  endfunction

  assign bus.mem_ack   = bus.mem_req && !stall;
  assign bus.mem_rdata = bus.mem_req ? rd(bus.mem_addr) : 32'h0;

  always @(posedge clk) begin
    cyc++;
    if (!reset && bus.mem_req && bus.mem_ack) begin
      acc_cnt++;
      if (bus.mem_we) wr_mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.iommu_translation_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("paddr", bus.iommu_paddr, e.paddr);
        chk("data_out", bus.iommu_data_out, e.data);
        chk("fault", {31'b0, bus.iommu_fault}, {31'b0, e.fault});
        chk("latency", 32'(cyc - e.cyc0), 32'(e.lat));
        chk("mem_accesses", 32'(acc_cnt - e.acc0), 32'(e.acc));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [31:0] ep,
                       input logic [31:0] ed, input logic ef,
                       input int lat, input int acc,
                       input int hold, input int flush_at);
    exp_t e;
    int d0;
    @(negedge clk);
    e.paddr = ep;
    e.data  = ed;
    e.fault = ef;
    e.lat   = lat;
    e.acc   = acc;
    e.cyc0  = cyc;
    e.acc0  = acc_cnt;
    sb.push_back(e);
    d0 = done_cnt;
    bus.iommu_daddr = a;
    bus.iommu_write_en = we;
    bus.iommu_write_data = wd;
    bus.iommu_translate_request = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.iommu_daddr = ~a;
        bus.iommu_write_en = ~we;
        bus.iommu_write_data = ~wd;
      end
      if (i >= hold) bus.iommu_translate_request = 1'b0;
      tlb_flush = (i == flush_at);
      if (done_cnt != d0 && i >= hold) break;
    end
    tlb_flush = 1'b0;
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL timeout daddr %h got no done want done", a);
      void'(sb.pop_back());
    end
  endtask

  initial begin
    int d0;
    bus.iommu_daddr = '0;
    bus.iommu_translate_request = 1'b0;
    bus.iommu_write_en = 1'b0;
    bus.iommu_write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'b0, bus.iommu_translation_done}, 32'h0);
    chk("rst_fault", {31'b0, bus.iommu_fault}, 32'h0);
    chk("rst_paddr", bus.iommu_paddr, 32'h0);
    chk("rst_data", bus.iommu_data_out, 32'h0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // miss then read; hit write
    issue(32'h3ABC, 0, 0, 32'h87ABC, 32'hDEADBEEF, 0, 5, 2, 1, 0);
    issue(32'h3ABC, 1, 32'h12345678, 32'h87ABC, 32'hDEADBEEF, 0, 3, 1, 1, 0);
    chk("mem_write", rd(32'h87ABC), 32'h12345678);
    // invalid PTE faults and is not cached
    issue(32'h5000, 0, 0, 0, 0, 1, 4, 1, 1, 0);
    issue(32'h5000, 0, 0, 0, 0, 1, 4, 1, 1, 0);
    // read-only page: fill, write fault on hit, read hit
    issue(32'h6010, 0, 0, 32'h90010, 32'hCAFE0001, 0, 5, 2, 1, 0);
    issue(32'h6020, 1, 32'h55, 0, 0, 1, 2, 0, 1, 0);
    issue(32'h6010, 0, 0, 32'h90010, 32'hCAFE0001, 0, 3, 1, 1, 0);
    chk("ro_untouched", rd(32'h90020), 32'h0);
    // write miss to read-only page faults after walk
    issue(32'h7000, 1, 32'h77, 0, 0, 1, 4, 1, 1, 0);
    chk("ro_miss_untouched", rd(32'hA0000), 32'h0);
    // flush in IDLE
    @(negedge clk);
    tlb_flush = 1'b1;
    @(negedge clk);
    tlb_flush = 1'b0;
    issue(32'h3ABC, 0, 0, 32'h87ABC, 32'h12345678, 0, 5, 2, 1, 0);
    // flush in LOOKUP: hit stands, next misses
    issue(32'h3ABC, 0, 0, 32'h87ABC, 32'h12345678, 0, 3, 1, 1, 1);
    issue(32'h3ABC, 0, 0, 32'h87ABC, 32'h12345678, 0, 5, 2, 1, 0);
    // flush in WALK suppresses fill
    issue(32'h6010, 0, 0, 32'h90010, 32'hCAFE0001, 0, 5, 2, 1, 2);
    issue(32'h6010, 0, 0, 32'h90010, 32'hCAFE0001, 0, 5, 2, 1, 0);
    // flush in CHECK, same edge as fill
    issue(32'h8040, 0, 0, 32'hB0040, 32'h0BADF00D, 0, 5, 2, 1, 3);
    issue(32'h8040, 0, 0, 32'hB0040, 32'h0BADF00D, 0, 5, 2, 1, 0);
    issue(32'h8040, 0, 0, 32'hB0040, 32'h0BADF00D, 0, 3, 1, 1, 0);
    // held request: one transaction only
    d0 = done_cnt;
    issue(32'h8040, 0, 0, 32'hB0040, 32'h0BADF00D, 0, 3, 1, 10, 0);
    repeat (5) @(negedge clk);
    chk("held_one_done", 32'(done_cnt - d0), 32'd1);
    // reset during stalled ACCESS
    stall = 1'b1;
    d0 = done_cnt;
    bus.iommu_daddr = 32'h8040;
    bus.iommu_write_en = 1'b0;
    bus.iommu_translate_request = 1'b1;
    @(negedge clk);
    bus.iommu_translate_request = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall_mem_req", {31'b0, bus.mem_req}, 32'h1);
    chk("stall_mem_addr", bus.mem_addr, 32'hB0040);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("abort_done", {31'b0, bus.iommu_translation_done}, 32'h0);
    reset = 1'b0;
    stall = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    // TLB was cleared by reset
    issue(32'h8040, 0, 0, 32'hB0040, 32'h0BADF00D, 0, 5, 2, 1, 0);
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
